// File: rtl/local_memory_arbiter.sv
// Two-requester arbiter (core primary, wishbone secondary) in front of a two-bank SRAM.
// Optional starvation guard for the secondary port: LOCAL_MEMORY_ARBITER_FAIRNESS_EN.
module local_memory_arbiter #(
  parameter int SRAM_ADDRESS_SIZE = 9,
  parameter int STARVE_LIMIT      = 4
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,

  input  logic                         primaryEnable,
  input  logic                         primaryWriteEnable,
  input  logic [3:0]                   primaryByteSelect,
  input  logic [23:0]                  primaryAddress,
  input  logic [31:0]                  primaryDataWrite,
  output logic [31:0]                  primaryDataRead,
  output logic                         primaryBusy,

  input  logic                         secondaryEnable,
  input  logic                         secondaryWriteEnable,
  input  logic [3:0]                   secondaryByteSelect,
  input  logic [23:0]                  secondaryAddress,
  input  logic [31:0]                  secondaryDataWrite,
  output logic [31:0]                  secondaryDataRead,
  output logic                         secondaryBusy,

  output logic                         clk0,
  output logic [1:0]                   csb0,
  output logic                         web0,
  output logic [3:0]                   wmask0,
  output logic [SRAM_ADDRESS_SIZE-1:0] addr0,
  output logic [31:0]                  din0,
  input  logic [63:0]                  dout0
);

  localparam int BANK_BIT = SRAM_ADDRESS_SIZE + 2;

  typedef enum logic {IDLE, RESPOND} state_t;

  state_t      state, state_next;
  logic        issue;
  logic        grant_sec;
  logic        sel_bank;
  logic        grant_p1;
  logic        bank_p1;
  logic        fair_sec;
  logic [31:0] resp_data;
  logic        unused_ok;

  assign clk0 = wb_clk_i;

`ifdef LOCAL_MEMORY_ARBITER_FAIRNESS_EN
  logic [2:0] starve_cnt;

  // Counts primary wins while the secondary is left waiting.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      starve_cnt <= 3'd0;
    end else if (!secondaryEnable || (issue && grant_sec)) begin
      starve_cnt <= 3'd0;
    end else if (issue) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign fair_sec  = (starve_cnt == 3'(STARVE_LIMIT));
  assign unused_ok = ^{primaryAddress[23:BANK_BIT+1], primaryAddress[1:0],
                       secondaryAddress[23:BANK_BIT+1], secondaryAddress[1:0]};
`else
  assign fair_sec  = 1'b0;
  assign unused_ok = ^{primaryAddress[23:BANK_BIT+1], primaryAddress[1:0],
                       secondaryAddress[23:BANK_BIT+1], secondaryAddress[1:0],
                       (STARVE_LIMIT != 0)};
`endif

  assign resp_data = bank_p1 ? dout0[63:32] : dout0[31:0];

  always_comb begin
    state_next        = state;
    issue             = 1'b0;
    grant_sec         = 1'b0;
    sel_bank          = 1'b0;
    csb0              = 2'b11;
    web0              = 1'b1;
    wmask0            = 4'b0000;
    addr0             = '0;
    din0              = 32'd0;
    primaryBusy       = primaryEnable;
    secondaryBusy     = secondaryEnable;
    primaryDataRead   = 32'd0;
    secondaryDataRead = 32'd0;
    case (state)
      IDLE: begin
        // Command goes to the SRAM in the same cycle as the grant; reset holds it off.
        if (!wb_rst_i && (primaryEnable || secondaryEnable)) begin
          issue      = 1'b1;
          grant_sec  = secondaryEnable && (!primaryEnable || fair_sec);
          state_next = RESPOND;
          if (grant_sec) begin
            sel_bank = secondaryAddress[BANK_BIT];
            web0     = !secondaryWriteEnable;
            wmask0   = secondaryByteSelect;
            addr0    = secondaryAddress[SRAM_ADDRESS_SIZE+1:2];
            din0     = secondaryDataWrite;
          end else begin
            sel_bank = primaryAddress[BANK_BIT];
            web0     = !primaryWriteEnable;
            wmask0   = primaryByteSelect;
            addr0    = primaryAddress[SRAM_ADDRESS_SIZE+1:2];
            din0     = primaryDataWrite;
          end
          csb0 = sel_bank ? 2'b01 : 2'b10;
        end
      end
      RESPOND: begin
        state_next = IDLE;
        // A reset landing here drops the response so no Busy-low pulse escapes.
        if (!wb_rst_i) begin
          if (grant_p1) begin
            secondaryBusy     = 1'b0;
            secondaryDataRead = resp_data;
          end else begin
            primaryBusy       = 1'b0;
            primaryDataRead   = resp_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant stage -> respond stage boundary.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      grant_p1 <= 1'b0;
      bank_p1  <= 1'b0;
    end else begin
      state <= state_next;
      if (issue) begin
        grant_p1 <= grant_sec;
        bank_p1  <= sel_bank;
      end
    end
  end

endmodule

// File: tb/tb_local_memory_arbiter.sv
// Directed bench for local_memory_arbiter; fairness expectations follow LOCAL_MEMORY_ARBITER_FAIRNESS_EN.
module tb_local_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_en, p_we, s_en, s_we;
  logic [3:0]  p_bs, s_bs;
  logic [23:0] p_addr, s_addr;
  logic [31:0] p_dw, s_dw, p_dr, s_dr;
  logic        p_busy, s_busy;
  logic        clk0, web0;
  logic [1:0]  csb0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [63:0] dout0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  local_memory_arbiter #(.SRAM_ADDRESS_SIZE(9), .STARVE_LIMIT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .primaryEnable(p_en), .primaryWriteEnable(p_we), .primaryByteSelect(p_bs),
    .primaryAddress(p_addr), .primaryDataWrite(p_dw), .primaryDataRead(p_dr),
    .primaryBusy(p_busy),
    .secondaryEnable(s_en), .secondaryWriteEnable(s_we), .secondaryByteSelect(s_bs),
    .secondaryAddress(s_addr), .secondaryDataWrite(s_dw), .secondaryDataRead(s_dr),
    .secondaryBusy(s_busy),
    .clk0(clk0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_csb"}, 64'(csb0), 64'h3);
    chk({tag, "_web"}, 64'(web0), 64'h1);
    chk({tag, "_wmask"}, 64'(wmask0), 64'h0);
    chk({tag, "_addr"}, 64'(addr0), 64'h0);
    chk({tag, "_din"}, 64'(din0), 64'h0);
    chk({tag, "_pdr"}, 64'(p_dr), 64'h0);
    chk({tag, "_sdr"}, 64'(s_dr), 64'h0);
  endtask

  initial begin
    logic exp_sec;
    rst = 1'b1;
    p_en = 0; p_we = 0; p_bs = 4'h0; p_addr = 24'h0; p_dw = 32'h0;
    s_en = 0; s_we = 0; s_bs = 4'h0; s_addr = 24'h0; s_dw = 32'h0;
    dout0 = 64'h0;

    // Reset state
    tick(); tick();
    #1;
    chk_idle("reset");
    chk("reset_pbusy", 64'(p_busy), 64'h0);
    chk("reset_sbusy", 64'(s_busy), 64'h0);
    rst = 1'b0;

    // Primary read, bank 0 word 2
    tick();
    p_en = 1; p_we = 0; p_bs = 4'hF; p_addr = 24'h000008;
    dout0 = {32'h11112222, 32'hDEADBEEF};
    #1;
    chk("rd_c0_csb", 64'(csb0), 64'h2);
    chk("rd_c0_web", 64'(web0), 64'h1);
    chk("rd_c0_addr", 64'(addr0), 64'h2);
    chk("rd_c0_pbusy", 64'(p_busy), 64'h1);
    chk("rd_c0_pdr", 64'(p_dr), 64'h0);
    tick();
    chk("rd_c1_csb", 64'(csb0), 64'h3);
    chk("rd_c1_pbusy", 64'(p_busy), 64'h0);
    chk("rd_c1_pdr", 64'(p_dr), 64'hDEADBEEF);
    p_en = 0;

    // Secondary write, bank 1 word 1
    tick();
    s_en = 1; s_we = 1; s_bs = 4'b0011; s_addr = 24'h000804; s_dw = 32'h12345678;
    dout0 = {32'hCAFEF00D, 32'h55555555};
    #1;
    chk("wr_c0_csb", 64'(csb0), 64'h1);
    chk("wr_c0_web", 64'(web0), 64'h0);
    chk("wr_c0_wmask", 64'(wmask0), 64'h3);
    chk("wr_c0_addr", 64'(addr0), 64'h1);
    chk("wr_c0_din", 64'(din0), 64'h12345678);
    chk("wr_c0_sbusy", 64'(s_busy), 64'h1);
    chk("wr_c0_pbusy", 64'(p_busy), 64'h0);
    tick();
    chk("wr_c1_sbusy", 64'(s_busy), 64'h0);
    chk("wr_c1_sdr", 64'(s_dr), 64'hCAFEF00D);
    chk("wr_c1_pdr", 64'(p_dr), 64'h0);
    chk("wr_c1_csb", 64'(csb0), 64'h3);
    s_en = 0; s_we = 0;

    // Simultaneous requests: primary first, then secondary
    tick();
    p_en = 1; p_we = 0; p_bs = 4'hF; p_addr = 24'h000010;
    s_en = 1; s_we = 0; s_bs = 4'hF; s_addr = 24'h00080C;
    dout0 = {32'hBBBB0001, 32'hAAAA0001};
    #1;
    chk("both_c0_csb", 64'(csb0), 64'h2);
    chk("both_c0_addr", 64'(addr0), 64'h4);
    chk("both_c0_pbusy", 64'(p_busy), 64'h1);
    chk("both_c0_sbusy", 64'(s_busy), 64'h1);
    tick();
    chk("both_c1_pbusy", 64'(p_busy), 64'h0);
    chk("both_c1_sbusy", 64'(s_busy), 64'h1);
    chk("both_c1_pdr", 64'(p_dr), 64'hAAAA0001);
    chk("both_c1_sdr", 64'(s_dr), 64'h0);
    p_en = 0;
    tick();
    chk("both_c2_csb", 64'(csb0), 64'h1);
    chk("both_c2_addr", 64'(addr0), 64'h3);
    chk("both_c2_sbusy", 64'(s_busy), 64'h1);
    chk("both_c2_pdr", 64'(p_dr), 64'h0);
    tick();
    chk("both_c3_sbusy", 64'(s_busy), 64'h0);
    chk("both_c3_sdr", 64'(s_dr), 64'hBBBB0001);
    s_en = 0;

    // Both held for ten grants
    tick();
    p_en = 1; p_addr = 24'h000000;
    s_en = 1; s_addr = 24'h000800;
    for (int k = 0; k < 10; k++) begin
`ifdef LOCAL_MEMORY_ARBITER_FAIRNESS_EN
      exp_sec = ((k % 5) == 4);
`else
      exp_sec = 1'b0;
`endif
      if (k != 0) tick();
      #1;
      chk($sformatf("order_g%0d_csb", k), 64'(csb0), exp_sec ? 64'h1 : 64'h2);
      tick();
      chk($sformatf("order_g%0d_pbusy", k), 64'(p_busy), exp_sec ? 64'h1 : 64'h0);
      chk($sformatf("order_g%0d_sbusy", k), 64'(s_busy), exp_sec ? 64'h0 : 64'h1);
    end
    p_en = 0; s_en = 0;
    tick();
    chk_idle("after_order");

    // Reset pulsed during the respond cycle
    p_en = 1; p_we = 0; p_bs = 4'hF; p_addr = 24'h000008;
    dout0 = {32'h0, 32'hDEADBEEF};
    #1;
    chk("rst_c0_csb", 64'(csb0), 64'h2);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_c1_pbusy", 64'(p_busy), 64'h1);
    chk("rst_c1_pdr", 64'(p_dr), 64'h0);
    chk("rst_c1_csb", 64'(csb0), 64'h3);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_c2_csb", 64'(csb0), 64'h2);
    chk("rst_c2_pbusy", 64'(p_busy), 64'h1);
    tick();
    chk("rst_c3_pbusy", 64'(p_busy), 64'h0);
    chk("rst_c3_pdr", 64'(p_dr), 64'hDEADBEEF);
    p_en = 0;
    tick();
    chk_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
